// File: rtl/timer_sequencer.sv
// Button-driven control FSM for the min/sec counter: debounces the buttons, sequences
// SET/RUN/PAUSE/DONE, times increment pulses and the alarm. Optional: TIMER_SEQUENCER_AUTO_REPEAT_EN.
module timer_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
   parameter int unsigned INC_PULSE_CYCLES = 100_000_000,
   parameter int unsigned ALARM_CYCLES     = 500_000_000,
   parameter int unsigned REPEAT_CYCLES    = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnStart,
   input  logic       btnStop,
   input  logic       btnMode,
   input  logic       btnSec,
   input  logic       btnMin,
   input  logic       finish,
   output logic       enable,
   output logic       forward,
   output logic       incrementSeconds,
   output logic       incrementMinutes,
   output logic       counterReset,
   output logic       alarm,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      SET   = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_MODE  = 2;
   localparam int B_SEC   = 3;
   localparam int B_MIN   = 4;

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int IW  = $clog2(INC_PULSE_CYCLES + 1);
   localparam int AW  = $clog2(ALARM_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [IW-1:0]  INC_LAST   = IW'(INC_PULSE_CYCLES - 1);
   localparam logic [AW-1:0]  ALARM_LAST = AW'(ALARM_CYCLES - 1);

   logic [4:0]     raw, sync1, sync2, level, press;
   logic [DBW-1:0] db_cnt [5];
   state_t         state_q;
   logic [IW-1:0]  inc_cnt;
   logic [AW-1:0]  alarm_cnt;
   logic           post_reset;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic          rep_active;
   logic          rep_min;
   logic [RW-1:0] rep_cnt;
`endif

   assign raw   = {btnMin, btnSec, btnMode, btnStop, btnStart};
   assign state = state_q;

   // press[i] is a one-cycle pulse coinciding with the debounced rising edge
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         press <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 5; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               level[i]  <= sync2[i];
               press[i]  <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= SET;
         enable           <= 1'b0;
         forward          <= 1'b0;
         incrementSeconds <= 1'b0;
         incrementMinutes <= 1'b0;
         counterReset     <= 1'b1;
         post_reset       <= 1'b1;
         alarm            <= 1'b0;
         inc_cnt          <= '0;
         alarm_cnt        <= '0;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
         rep_active       <= 1'b0;
         rep_min          <= 1'b0;
         rep_cnt          <= '0;
`endif
      end else begin
         // counter stays in reset for one more cycle after our own reset releases
         counterReset <= post_reset;
         post_reset   <= 1'b0;
         case (state_q)
            SET: begin
               if (press[B_MODE]) forward <= ~forward;
               if (incrementSeconds || incrementMinutes) begin
                  if (inc_cnt == INC_LAST) begin
                     incrementSeconds <= 1'b0;
                     incrementMinutes <= 1'b0;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
                     rep_active <= 1'b1;
                     rep_min    <= incrementMinutes;
                     rep_cnt    <= '0;
`endif
                  end else begin
                     inc_cnt <= inc_cnt + 1'b1;
                  end
               end else if (press[B_SEC]) begin
                  incrementSeconds <= 1'b1;
                  inc_cnt          <= '0;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
                  rep_active       <= 1'b0;
`endif
               end else if (press[B_MIN]) begin
                  incrementMinutes <= 1'b1;
                  inc_cnt          <= '0;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
                  rep_active       <= 1'b0;
`endif
               end else if (press[B_START]) begin
                  state_q <= RUN;
                  enable  <= 1'b1;
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
                  rep_active <= 1'b0;
`endif
               end
`ifdef TIMER_SEQUENCER_AUTO_REPEAT_EN
               else if (rep_active) begin
                  if (!(rep_min ? level[B_MIN] : level[B_SEC])) begin
                     rep_active <= 1'b0;
                  end else if (rep_cnt == REP_LAST) begin
                     rep_active       <= 1'b0;
                     incrementSeconds <= ~rep_min;
                     incrementMinutes <= rep_min;
                     inc_cnt          <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
`endif
            end
            RUN: begin
               if (finish) begin
                  state_q   <= DONE;
                  enable    <= 1'b0;
                  alarm     <= 1'b1;
                  alarm_cnt <= '0;
               end else if (press[B_STOP]) begin
                  state_q <= PAUSE;
                  enable  <= 1'b0;
               end
            end
            PAUSE: begin
               if (press[B_START]) begin
                  state_q <= RUN;
                  enable  <= 1'b1;
               end else if (press[B_STOP]) begin
                  state_q      <= SET;
                  counterReset <= 1'b1;
               end
            end
            DONE: begin
               if (press[B_START] || press[B_STOP]) begin
                  state_q      <= SET;
                  alarm        <= 1'b0;
                  counterReset <= 1'b1;
               end else if (alarm) begin
                  if (alarm_cnt == ALARM_LAST) alarm <= 1'b0;
                  else alarm_cnt <= alarm_cnt + 1'b1;
               end
            end
            default: begin
               state_q <= SET;
               enable  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Control FSM that sequences the minutes/seconds countdown/countup counter.
- Turns raw push-buttons into the counter's `enable`, `forward`, `incrementSeconds`, `incrementMinutes` and counter reset.
- Watches the counter's `finish` flag and drives an alarm output for the VGA monitor / LED.
- Sits between the board button inputs and the counter; runs on the 100 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a button must be stable before its level is accepted (10 ms).
- INC_PULSE_CYCLES, 100_000_000, cycles each increment output is held high (one full 1 Hz period, so the counter samples it).
- ALARM_CYCLES, 500_000_000, cycles alarm stays high after finish (5 s).
- REPEAT_CYCLES, 50_000_000, hold time before the next auto-repeat increment (used only with the optional feature).

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- btnStart  input  1  raw start/resume button, active-high
- btnStop  input  1  raw pause button; a second press while paused clears
- btnMode  input  1  raw direction toggle button (count up/down)
- btnSec  input  1  raw add-second button
- btnMin  input  1  raw add-minute button
- finish  input  1  counter reached terminal value, level
- enable  output  1  counter run enable
- forward  output  1  count direction (1 = up)
- incrementSeconds  output  1  seconds increment request
- incrementMinutes  output  1  minutes increment request
- counterReset  output  1  synchronous reset to the counter
- alarm  output  1  finish indication
- state  output  3  current FSM state encoding

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- Values on reset:
  - state = SET (3'd1)
  - enable = 0, forward = 0
  - incrementSeconds = 0, incrementMinutes = 0
  - counterReset = 1 for exactly one cycle after reset deasserts, then 0
  - alarm = 0
  - all debounce and timer counters = 0
- Button conditioning:
  - Each button passes a 2-flop synchronizer, then a debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a one-cycle pulse on the debounced rising edge. All FSM decisions use press events only.
- State encoding: SET=1, RUN=2, PAUSE=3, DONE=4.
- SET:
  - enable = 0.
  - btnMode press toggles `forward`.
  - btnSec press: incrementSeconds = 1 for INC_PULSE_CYCLES, then 0.
  - btnMin press: incrementMinutes = 1 for INC_PULSE_CYCLES, then 0.
  - Only one increment pulse is active at a time. While a pulse is active, further btnSec/btnMin presses are ignored (dropped, not queued).
  - If btnSec and btnMin press in the same cycle, seconds wins.
  - btnStart press goes to RUN, but only when no increment pulse is active. Otherwise it is ignored.
- RUN:
  - enable = 1; increments are held 0; btnMode is ignored.
  - btnStop press goes to PAUSE.
  - finish = 1 goes to DONE. If finish and btnStop occur in the same cycle, finish wins.
- PAUSE:
  - enable = 0.
  - btnStart press goes to RUN.
  - btnStop press: counterReset pulses high for one cycle, then go to SET.
- DONE:
  - enable = 0; alarm = 1 from the entry cycle.
  - Alarm timer counts ALARM_CYCLES. On expiry, alarm = 0 and the FSM stays in DONE.
  - Any btnStart or btnStop press: alarm = 0, counterReset pulses for one cycle, go to SET. This also cuts the alarm short.
- General rules:
  - Every transition takes effect on the clock edge after the press event (1-cycle latency from the press pulse).
  - Timers saturate; they never wrap.
  - `forward` is retained across all states. It changes only in SET or on reset.
  - Reset mid-pulse or mid-alarm aborts immediately to the reset values. No partial increment is held.

Optional Feature:
- Macro: TIMER_SEQUENCER_AUTO_REPEAT_EN.
- Defined: in SET, a held btnSec/btnMin (debounced level still 1) re-fires an increment pulse every REPEAT_CYCLES after the previous pulse ends, until the button is released.
- Not defined: exactly one increment pulse per press; holding the button has no further effect.
- Test values are for sim with DEBOUNCE_CYCLES=4, INC_PULSE_CYCLES=8, ALARM_CYCLES=20, REPEAT_CYCLES=16.

Test Plan:
- Reset released -> state=1, enable=0, alarm=0, counterReset high exactly 1 cycle; a 3-cycle btnStart glitch -> no state change.
- SET, btnSec held 10 cycles -> incrementSeconds high exactly 8 cycles; a btnMin press during that pulse -> incrementMinutes stays 0.
- SET, btnMode press then btnStart -> forward=1, state=2, enable=1; btnStop -> state=3, enable=0; btnStart -> state=2.
- RUN, finish and btnStop pressed on the same cycle -> state=4, alarm=1 for 20 cycles then 0; btnStart -> counterReset 1 cycle, state=1, forward still 1.
- PAUSE, btnStop -> counterReset 1 cycle, state=1; reset asserted during an active incrementMinutes -> incrementMinutes=0 on the next edge.
- With TIMER_SEQUENCER_AUTO_REPEAT_EN, btnMin held 60 cycles -> 3 pulses of 8 cycles, starting 24 cycles apart; without the macro -> 1 pulse.
